fifo_math_sequencer: RTL and testbench

- Sequences one vector-math operation batch: pops operand vectors from two fifo_array instances (A, B), issues them to a fixed-latency math unit, and forwards each result vector to an output fifo_array.
- Uses credit-based issue plus an internal result buffer, so no result is dropped when the output FIFO asserts full mid-pipeline.
- Sits between the operand/result fifo_arrays and the math core in the fifo_math datapath.

---
 rtl/fifo_math_sequencer.sv | 153 +++++++++++++++
 tb/tb_fifo_math_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_math_sequencer.sv
// fifo_math_sequencer
//   Runs one batch of vector-math operations. Operand vectors are popped in
//   lockstep from two fifo_arrays (A, B), handed to a fixed-latency math unit,
//   and every returned result vector is parked in a small result buffer and
//   then forwarded to the output fifo_array. Issue is credit based: an
//   operation only issues while (in_flight + buffered) < RES_DEPTH, so a
//   stalled output FIFO can never cause a returning result to be dropped.
//
// Ports
//   clock_i, reset_ni          clock (rising edge), async active-low reset
//   start_i, op_count_i        batch start pulse and operation count
//   busy_o, done_o, err_o      batch active, one-cycle completion, sticky error
//   a_empty_i / a_rd_en_o      operand A FIFO status / pop
//   b_empty_i / b_rd_en_o      operand B FIFO status / pop
//   math_in_valid_o            operands on the FIFO dout buses are valid
//   math_out_valid_i, math_res_i  result strobe and vector from the math unit
//   out_full_i / out_wr_en_o / out_din_o  output FIFO full / push / data
module fifo_math_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_SIZE = 3,
  parameter int RES_DEPTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clock_i,
  input  logic                             reset_ni,
  input  logic                             start_i,
  input  logic [CNT_WIDTH-1:0]             op_count_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  input  logic                             a_empty_i,
  output logic                             a_rd_en_o,
  input  logic                             b_empty_i,
  output logic                             b_rd_en_o,
  output logic                             math_in_valid_o,
  input  logic                             math_out_valid_i,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] math_res_i,
  input  logic                             out_full_i,
  output logic                             out_wr_en_o,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_din_o
);

  localparam int VW = ARRAY_SIZE * DATA_WIDTH;
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [CW-1:0]        in_flight_q, in_flight_d;
  logic [CW-1:0]        buf_count_q, buf_count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 err_q, err_d;
  logic                 miv_q;
  logic [VW-1:0]        mem_q [RES_DEPTH];

  logic          issue, push, res_ok;
  logic [CW:0]   credit_sum;

  // Credit sum kept one bit wider so it can never wrap before the compare.
  assign credit_sum = {1'b0, in_flight_q} + {1'b0, buf_count_q};
  assign issue  = (state_q == S_RUN) && (remaining_q != '0) && !a_empty_i &&
                  !b_empty_i && (credit_sum < (CW+1)'(RES_DEPTH));
  assign push   = (buf_count_q != '0) && !out_full_i;
  // A result with nothing outstanding is a protocol error and is not stored.
  assign res_ok = math_out_valid_i && (in_flight_q != '0);

  // State register
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (remaining_q == '0) state_d = S_DRAIN;
      S_DRAIN: if (in_flight_q == '0 && buf_count_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o          = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o          = (state_q == S_DONE);
    err_o           = err_q;
    a_rd_en_o       = issue;
    b_rd_en_o       = issue;
    math_in_valid_o = miv_q;
    out_wr_en_o     = push;
    // Forced to zero when empty so reset shows a clean bus without
    // having to reset the buffer storage.
    out_din_o       = (buf_count_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

  // Counters and pointers
  always_comb begin
    remaining_d = remaining_q;
    if (state_q == S_IDLE && start_i) remaining_d = op_count_i;
    else if (issue)                   remaining_d = remaining_q - CNT_WIDTH'(1);

    in_flight_d = in_flight_q;
    unique case ({issue, res_ok})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase

    buf_count_d = buf_count_q;
    unique case ({res_ok, push})
      2'b10:   buf_count_d = buf_count_q + CW'(1);
      2'b01:   buf_count_d = buf_count_q - CW'(1);
      default: buf_count_d = buf_count_q;
    endcase

    wr_ptr_d = wr_ptr_q + PW'(res_ok);
    rd_ptr_d = rd_ptr_q + PW'(push);
    err_d    = err_q | (math_out_valid_i && (in_flight_q == '0));
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      remaining_q <= '0;
      in_flight_q <= '0;
      buf_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      miv_q       <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      in_flight_q <= in_flight_d;
      buf_count_q <= buf_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      // FIFO dout appears one cycle after the pop.
      miv_q       <= issue;
    end
  end

  // Result storage; contents are don't-care until counted in buf_count.
  always_ff @(posedge clock_i) begin
    if (res_ok) mem_q[wr_ptr_q] <= math_res_i;
  end

endmodule

// File: tb/tb_fifo_math_sequencer.sv
// Bench for fifo_math_sequencer: models the A/B fifo_arrays (registered read),
// a 3-cycle math unit computing lane-wise A+B, and checks pushes against
// expected sums computed at preload time.
module tb_fifo_math_sequencer;
  localparam int DW = 32, AS = 3, RD = 8, CNTW = 16, VW = DW*AS, LAT = 3;

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [CNTW-1:0] op_count = '0;
  logic            busy, done, err, a_rd_en, b_rd_en, math_in_valid;
  logic            a_empty, b_empty, math_out_valid, out_full = 1'b0, out_wr_en;
  logic [VW-1:0]   math_res, out_din;
  logic            b_block = 1'b0, inj = 1'b0, mon_en = 1'b1;

  logic [VW-1:0]   a_mem [256], b_mem [256], exp_mem [256];
  int              a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0, e_wr = 0, e_rd = 0;
  logic [VW-1:0]   a_dout = '0, b_dout = '0;
  logic [LAT-1:0]          mv_p;
  logic [LAT-1:0][VW-1:0]  mr_p;

  int total = 0, bad = 0, cyc = 0, pops = 0, pushes = 0, done_cnt = 0;

  always #5 clk = ~clk;

  fifo_math_sequencer #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .RES_DEPTH(RD), .CNT_WIDTH(CNTW)) dut (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start), .op_count_i(op_count),
    .busy_o(busy), .done_o(done), .err_o(err),
    .a_empty_i(a_empty), .a_rd_en_o(a_rd_en), .b_empty_i(b_empty), .b_rd_en_o(b_rd_en),
    .math_in_valid_o(math_in_valid), .math_out_valid_i(math_out_valid), .math_res_i(math_res),
    .out_full_i(out_full), .out_wr_en_o(out_wr_en), .out_din_o(out_din));

  assign a_empty = (a_rd == a_wr);
  assign b_empty = (b_rd == b_wr) | b_block;
  assign math_out_valid = mv_p[LAT-1] | inj;
  assign math_res = mr_p[LAT-1];

  function automatic logic [VW-1:0] add_vec(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    for (int l = 0; l < AS; l++) r[l*DW +: DW] = a[l*DW +: DW] + b[l*DW +: DW];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_rd_en) begin a_dout <= a_mem[a_rd]; a_rd <= a_rd + 1; end
    if (b_rd_en) begin b_dout <= b_mem[b_rd]; b_rd <= b_rd + 1; end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mv_p <= '0;
    else begin
      mv_p <= {mv_p[LAT-2:0], math_in_valid};
      mr_p[0] <= add_vec(a_dout, b_dout);
      for (int i = 1; i < LAT; i++) mr_p[i] <= mr_p[i-1];
    end
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle protocol monitor and output scoreboard
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("rd_en_pair", VW'(a_rd_en), VW'(b_rd_en));
      if (a_rd_en) begin
        chk("pop_while_empty", VW'((a_rd == a_wr) || (b_rd == b_wr) || b_block), VW'(0));
        pops++;
      end
      if (out_wr_en) begin
        chk("push_while_full", VW'(out_full), VW'(0));
        chk("push_in_range", VW'(e_rd < e_wr), VW'(1));
        chk("push_data", out_din, exp_mem[e_rd[7:0]]);
        e_rd++;
        pushes++;
      end
      if (done) begin
        done_cnt++;
        chk("busy_in_done", VW'(busy), VW'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input int n);
    logic [VW-1:0] av, bv, ev;
    logic signed [DW-1:0] x, y;
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < AS; l++) begin
        x = DW'(a_wr*16 + l + 1);
        y = DW'(l*1000 - a_wr*5 - 3);
        av[l*DW +: DW] = x;
        bv[l*DW +: DW] = y;
        ev[l*DW +: DW] = DW'(a_wr*16 + l + 1 + l*1000 - a_wr*5 - 3);
      end
      a_mem[a_wr[7:0]] = av; b_mem[b_wr[7:0]] = bv; exp_mem[e_wr[7:0]] = ev;
      a_wr++; b_wr++; e_wr++;
    end
  endtask

  typedef struct {
    int n;           // op_count (and vectors preloaded)
    bit toggle_b;    // b_empty forced high every other cycle
    int full_cyc;    // cycles out_full held high from start (0 = never)
    int stall_pops;  // expected pops while out_full is high
    bit consec;      // expect pops on exactly the first n RUN cycles
    bit exp_err;
  } vec_t;

  vec_t vt [5];

  task automatic run_vec(input vec_t v, input int idx);
    int p0, q0, d0, k;
    bit got;
    string s;
    s = $sformatf("v%0d", idx);
    preload(v.n);
    p0 = pops; q0 = pushes; d0 = done_cnt;
    start = 1'b1; op_count = CNTW'(v.n); out_full = (v.full_cyc > 0);
    tick();
    start = 1'b0;
    got = 1'b0;
    k = 1;
    while (k < 600 && !got) begin
      @(negedge clk);
      if (v.consec && k <= v.n + 1) chk({s, "_consec"}, VW'(a_rd_en), VW'(k <= v.n));
      if (done) got = 1'b1;
      tick();
      k++;
      if (v.full_cyc > 0 && k == v.full_cyc) begin
        chk({s, "_stall_pops"}, VW'(pops - p0), VW'(v.stall_pops));
        out_full = 1'b0;
      end
      if (v.toggle_b) b_block = ~b_block;
    end
    b_block = 1'b0; out_full = 1'b0;
    chk({s, "_done_seen"}, VW'(got), VW'(1));
    chk({s, "_pops"}, VW'(pops - p0), VW'(v.n));
    chk({s, "_pushes"}, VW'(pushes - q0), VW'(v.n));
    chk({s, "_done_cnt"}, VW'(done_cnt - d0), VW'(1));
    chk({s, "_busy_after"}, VW'(busy), VW'(0));
    chk({s, "_err"}, VW'(err), VW'(v.exp_err));
  endtask

  initial begin
    int p0, q0, d0, k, sc;
    bit got;
    vt[0] = '{n: 4,  toggle_b: 0, full_cyc: 0,  stall_pops: 0, consec: 1, exp_err: 0};
    vt[1] = '{n: 20, toggle_b: 0, full_cyc: 30, stall_pops: 8, consec: 0, exp_err: 0};
    vt[2] = '{n: 6,  toggle_b: 1, full_cyc: 0,  stall_pops: 0, consec: 0, exp_err: 0};
    vt[3] = '{n: 9,  toggle_b: 1, full_cyc: 40, stall_pops: 8, consec: 0, exp_err: 0};
    vt[4] = '{n: 12, toggle_b: 0, full_cyc: 0,  stall_pops: 0, consec: 1, exp_err: 0};

    // Reset state
    #2;
    chk("rst_outputs", VW'({busy, done, err, a_rd_en, b_rd_en, math_in_valid, out_wr_en}), VW'(0));
    chk("rst_out_din", out_din, VW'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(vt[i], i);
      tick();
    end

    // op_count=0: done on the third cycle after the start cycle, no traffic
    preload(2);
    p0 = pops; q0 = pushes; d0 = done_cnt;
    start = 1'b1; op_count = '0; sc = cyc;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("zero_done_c%0d", c), VW'(done), VW'(c == 3));
      chk($sformatf("zero_busy_c%0d", c), VW'(busy), VW'(c < 3));
      tick();
    end
    chk("zero_pops", VW'(pops - p0), VW'(0));
    chk("zero_pushes", VW'(pushes - q0), VW'(0));
    chk("zero_done_cnt", VW'(done_cnt - d0), VW'(1));
    chk("zero_start_cyc", VW'(cyc - sc), VW'(5));

    // Stray result while idle sets a sticky error and stores nothing
    inj = 1'b1;
    tick();
    inj = 1'b0;
    @(negedge clk);
    chk("err_set", VW'(err), VW'(1));
    chk("err_buf_empty", VW'(out_wr_en), VW'(0));
    tick();
    // Batch of 2 (uses the 2 leftover vectors) with a second start mid-RUN
    preload(3);
    p0 = pops; q0 = pushes;
    start = 1'b1; op_count = CNTW'(2);
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op_count = CNTW'(7);
    tick();
    start = 1'b0;
    got = 1'b0;
    k = 0;
    while (k < 200 && !got) begin
      @(negedge clk);
      if (done) got = 1'b1;
      tick();
      k++;
    end
    chk("ign_done_seen", VW'(got), VW'(1));
    chk("ign_pops", VW'(pops - p0), VW'(2));
    chk("ign_pushes", VW'(pushes - q0), VW'(2));
    chk("err_sticky", VW'(err), VW'(1));
    tick();

    // Async reset in the middle of RUN (3 vectors still queued + 3 more)
    preload(3);
    start = 1'b1; op_count = CNTW'(6);
    tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_busy", VW'(busy), VW'(1));
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", VW'({busy, done, err, a_rd_en, b_rd_en, math_in_valid, out_wr_en}), VW'(0));
    chk("arst_out_din", out_din, VW'(0));
    tick();
    rst_n = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("post_rst_idle", VW'({busy, done, a_rd_en, err}), VW'(0));
    chk("post_rst_fifo_kept", VW'(a_rd != a_wr), VW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
